frame_sum_sink: RTL

- Downstream consumer attached directly to the pop side of the team's valid/grant FIFO.
- Takes a word stream whose MSB is an end-of-frame marker and the lower DATA_WIDTH bits are payload.
- Accumulates a per-frame modular sum and word count, then presents one result record per frame on its own valid/grant output handshake.
- Back-pressures the FIFO while a result is pending.

---
 rtl/frame_sum_sink.sv | 122 ++++++++++++
 1 files changed

// File: rtl/frame_sum_sink.sv
// rtl/frame_sum_sink.sv - per-frame modular sum/count sink on the pop side of a valid/grant FIFO
module frame_sum_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 16,
    parameter int CNT_WIDTH  = $clog2(MAX_WORDS + 1),
    parameter int FRM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH:0]   pop_data_i,
    input  logic                  pop_valid_i,
    output logic                  pop_grant_o,
    output logic                  res_valid_o,
    input  logic                  res_grant_i,
    output logic [DATA_WIDTH-1:0] res_sum_o,
    output logic [CNT_WIDTH-1:0]  res_count_o,
    output logic                  res_overflow_o,
    output logic [FRM_WIDTH-1:0]  frames_o
);

    localparam logic [0:0] ST_ACCUM  = 1'b0;
    localparam logic [0:0] ST_REPORT = 1'b1;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WORDS);

    logic [0:0]            state_q,     state_d;
    logic [DATA_WIDTH-1:0] acc_sum_q,   acc_sum_d;
    logic [CNT_WIDTH-1:0]  acc_cnt_q,   acc_cnt_d;
    logic                  acc_ovf_q,   acc_ovf_d;
    logic [DATA_WIDTH-1:0] res_sum_q,   res_sum_d;
    logic [CNT_WIDTH-1:0]  res_cnt_q,   res_cnt_d;
    logic                  res_ovf_q,   res_ovf_d;
    logic [FRM_WIDTH-1:0]  frames_q,    frames_d;

    logic                  in_xfer;
    logic                  in_last;
    logic [DATA_WIDTH-1:0] in_payload;
    logic [DATA_WIDTH-1:0] sum_next;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  ovf_next;
    logic                  cnt_full;

    // Handshake outputs come straight from state so no input reaches an output combinationally
    assign pop_grant_o    = (state_q == ST_ACCUM);
    assign res_valid_o    = (state_q == ST_REPORT);
    assign res_sum_o      = res_sum_q;
    assign res_count_o    = res_cnt_q;
    assign res_overflow_o = res_ovf_q;
    assign frames_o       = frames_q;

    assign in_xfer    = pop_valid_i && pop_grant_o;
    assign in_last    = pop_data_i[DATA_WIDTH];
    assign in_payload = pop_data_i[DATA_WIDTH-1:0];

    // Running values that include the word being accepted this cycle
    assign cnt_full = (acc_cnt_q == MAX_CNT);
    assign sum_next = acc_sum_q + in_payload;
    assign cnt_next = cnt_full ? MAX_CNT : acc_cnt_q + 1'b1;
    assign ovf_next = acc_ovf_q | cnt_full;

    // Next-state: accumulate in ACCUM, close the frame on last, hold the record until granted
    always_comb begin
        state_d   = state_q;
        acc_sum_d = acc_sum_q;
        acc_cnt_d = acc_cnt_q;
        acc_ovf_d = acc_ovf_q;
        res_sum_d = res_sum_q;
        res_cnt_d = res_cnt_q;
        res_ovf_d = res_ovf_q;
        frames_d  = frames_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_xfer) begin
                    if (in_last) begin
                        res_sum_d = sum_next;
                        res_cnt_d = cnt_next;
                        res_ovf_d = ovf_next;
                        acc_sum_d = '0;
                        acc_cnt_d = '0;
                        acc_ovf_d = 1'b0;
                        frames_d  = frames_q + 1'b1;
                        state_d   = ST_REPORT;
                    end else begin
                        acc_sum_d = sum_next;
                        acc_cnt_d = cnt_next;
                        acc_ovf_d = ovf_next;
                    end
                end
            end
            ST_REPORT: begin
                if (res_grant_i) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State registers; reset discards any partial frame and pending record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACCUM;
            acc_sum_q <= '0;
            acc_cnt_q <= '0;
            acc_ovf_q <= 1'b0;
            res_sum_q <= '0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_sum_q <= acc_sum_d;
            acc_cnt_q <= acc_cnt_d;
            acc_ovf_q <= acc_ovf_d;
            res_sum_q <= res_sum_d;
            res_cnt_q <= res_cnt_d;
            res_ovf_q <= res_ovf_d;
            frames_q  <= frames_d;
        end
    end

endmodule
